sram_ctrl: RTL

Single-port request/response controller that sits directly upstream of the 256×32 `SRAM` block and is the only agent driving its `WE`/`addr`/`data_in`. It accepts one CPU-side load or store at a time over a valid/ready handshake. Partial-word stores are performed as read-modify-write using per-byte enables. Every accepted request produces exactly one single-cycle response pulse.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_be_merge.sv | 22 ++
 rtl/sram_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request controller: default bus widths,
// FSM state encoding and a small state-decode helper.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_RMW_RD   = 3'd4,
        ST_RMW_WAIT = 3'd5,
        ST_RMW_WR   = 3'd6,
        ST_ACK      = 3'd7
    } state_t;

    // States in which the SRAM write strobe is asserted (before reset gating).
    function automatic logic state_writes(input state_t s);
        return (s == ST_WR) || (s == ST_RMW_WR);
    endfunction

endpackage

// File: rtl/sram_be_merge.sv
// Byte-enable merge: each byte comes from new_data where its enable is set,
// otherwise from old_data. Purely combinational.
module sram_be_merge #(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding load/store controller in front of a 256x32 synchronous
// SRAM; partial-word stores are done as read-modify-write.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;
    logic [DATA_W-1:0] merged;

    sram_be_merge #(.DATA_W(DATA_W)) u_merge (
        .old_data (sram_dout),
        .new_data (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    assign req_ready = (state == ST_IDLE);
    assign sram_addr = addr_q;
    assign sram_din  = (state == ST_RMW_WR) ? merged_q : wdata_q;
    // Gated by res so an in-flight write can never land during a reset cycle.
    assign sram_we   = !res && we_q && state_writes(state);

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        we_q    <= req_we;
                        if (!req_we) begin
                            state <= ST_RD;
                        end else if (&req_be) begin
                            state <= ST_WR;
                        end else if (|req_be) begin
                            state <= ST_RMW_RD;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rsp_rdata <= sram_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_WR: begin
                    rsp_rdata <= wdata_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_RMW_RD: begin
                    state <= ST_RMW_WAIT;
                end
                ST_RMW_WAIT: begin
                    merged_q <= merged;
                    state    <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    rsp_rdata <= merged_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ACK: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
